// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared types, widths and the round-robin pick function used by the
// multiplier-sharing scheduler and its arbiter.
//   OPW     : operand width (signed 4-bit)
//   PW      : product width (signed 8-bit)
//   MAX_REQ : widest requester vector rr_pick accepts (requesters 2..8)
//   MAX_IDW : index width matching MAX_REQ
// -----------------------------------------------------------------------------
package mult_pkg;

    localparam int OPW     = 4;
    localparam int PW      = 8;
    localparam int MAX_REQ = 8;
    localparam int MAX_IDW = 3;

    typedef logic signed [OPW-1:0] op_t;
    typedef logic signed [PW-1:0]  prod_t;

    // Returns the first index i with valid[i]=1, searching ptr, ptr+1, ...
    // modulo n. Callers zero-extend narrower vectors; with no valid bit set
    // the result is 0 and the caller must qualify it with |valid.
    function automatic logic [MAX_IDW-1:0] rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input logic [MAX_IDW-1:0] ptr,
        input int                 n
    );
        logic [MAX_IDW-1:0] pick;
        logic               found;
        int                 idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = int'(ptr) + k;
            // ptr < n and k < n, so one subtraction is enough to wrap.
            if (idx >= n) begin
                idx = idx - n;
            end
            if (!found && (k < n) && valid[idx[MAX_IDW-1:0]]) begin
                pick  = idx[MAX_IDW-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mult_wallace.sv
// -----------------------------------------------------------------------------
// mult_wallace
// Combinational 4x4 signed multiplier. Partial products are reduced with two
// layers of 3:2 carry-save compressors followed by one carry-propagate add.
//   operand_a    in  4  signed multiplicand
//   operand_b    in  4  signed multiplier
//   result_final out 9  signed product, sign-extended to 9 bits
// -----------------------------------------------------------------------------
module mult_wallace (
    input  logic [3:0] operand_a,
    input  logic [3:0] operand_b,
    output logic [8:0] result_final
);

    logic [8:0] a_ext;
    logic [8:0] pp0, pp1, pp2, pp3n;
    logic [8:0] s1, c1, s2, c2;

    always_comb begin
        a_ext = {{5{operand_a[3]}}, operand_a};
        pp0   = operand_b[0] ? a_ext        : 9'd0;
        pp1   = operand_b[1] ? (a_ext << 1) : 9'd0;
        pp2   = operand_b[2] ? (a_ext << 2) : 9'd0;
        // b[3] carries weight -8: subtract (a << 3) as its inverse plus a
        // carry-in that is folded into the final adder.
        pp3n  = operand_b[3] ? ~(a_ext << 3) : 9'd0;

        s1 = pp0 ^ pp1 ^ pp2;
        c1 = ((pp0 & pp1) | (pp0 & pp2) | (pp1 & pp2)) << 1;
        s2 = s1 ^ c1 ^ pp3n;
        c2 = ((s1 & c1) | (s1 & pp3n) | (c1 & pp3n)) << 1;

        // Everything is modulo 2^9; carries beyond bit 8 are meaningless.
        result_final = s2 + c2 + {8'd0, operand_b[3]};
    end

endmodule

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin grant. The priority pointer lives in the
// parent; this block only searches from it.
//   req       in  NUM_REQ  request vector
//   ptr       in  ID_W     index searched first
//   enable    in  1        when low no grant is issued
//   grant     out NUM_REQ  one-hot grant (all zero when nothing granted)
//   grant_idx out ID_W     binary index of the winner (valid when |grant)
// -----------------------------------------------------------------------------
module rr_arbiter
    import mult_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    logic [MAX_IDW-1:0] pick;

    always_comb begin
        pick      = rr_pick(MAX_REQ'(req), MAX_IDW'(ptr), NUM_REQ);
        grant_idx = pick[ID_W-1:0];
        grant     = '0;
        if (enable) begin
            // ANDing with req keeps grant zero when no request is present.
            for (int i = 0; i < NUM_REQ; i++) begin
                if (pick == MAX_IDW'(i)) begin
                    grant[i] = req[i];
                end
            end
        end
    end

endmodule

// File: rtl/mult_share_sched.sv
// -----------------------------------------------------------------------------
// mult_share_sched
// Shares one combinational 4x4 signed multiplier between NUM_REQ requesters.
// Two-stage pipeline: S1 holds the granted operands, the multiplier sits
// between S1 and S2, S2 holds the product for the response channel.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Requester inputs (req_valid/req_a/req_b) and resp_valid/
// resp_id/resp_product hold steady while valid is high and ready is low on
// the response side; requesters may drop req_valid while not accepted.
//
//   clk          in  1          clock, rising edge
//   rst          in  1          synchronous active-high reset
//   req_valid    in  NUM_REQ    per-requester operand valid
//   req_a        in  NUM_REQ*4  packed signed A operands, [4i+3:4i]
//   req_b        in  NUM_REQ*4  packed signed B operands, [4i+3:4i]
//   req_ready    out NUM_REQ    per-requester accept, at most one high
//   resp_valid   out 1          product valid
//   resp_ready   in  1          downstream accept
//   resp_id      out ID_W       requester that issued the operands
//   resp_product out 8          signed product
//   ops_count    out CNT_W      completed response handshakes (wraps)
// -----------------------------------------------------------------------------
module mult_share_sched
    import mult_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int CNT_W   = 16,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*OPW-1:0] req_a,
    input  logic [NUM_REQ*OPW-1:0] req_b,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [ID_W-1:0]        resp_id,
    output logic [PW-1:0]          resp_product,
    output logic [CNT_W-1:0]       ops_count
);

    logic [ID_W-1:0]  ptr_q,  ptr_d;
    logic             v1_q,   v1_d;
    op_t              a1_q,   a1_d;
    op_t              b1_q,   b1_d;
    logic [ID_W-1:0]  id1_q,  id1_d;
    logic             v2_q,   v2_d;
    prod_t            prod_q, prod_d;
    logic [ID_W-1:0]  id2_q,  id2_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;

    logic               advance;
    logic               accept;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic [8:0]         mult_res;
    logic               unused_mult_msb;

    // The whole pipeline moves together; S2 frees up when it is empty or
    // its content is being taken this cycle.
    assign advance = !v2_q || resp_ready;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr_q),
        .enable    (advance && !rst),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = grant;
    assign accept    = |grant;

    mult_wallace u_mult (
        .operand_a    (a1_q),
        .operand_b    (b1_q),
        .result_final (mult_res)
    );

    // The 4x4 signed product always fits in 8 bits; bit 8 is only sign.
    assign unused_mult_msb = mult_res[8];

    always_comb begin
        ptr_d  = ptr_q;
        v1_d   = v1_q;
        a1_d   = a1_q;
        b1_d   = b1_q;
        id1_d  = id1_q;
        v2_d   = v2_q;
        prod_d = prod_q;
        id2_d  = id2_q;
        cnt_d  = cnt_q;

        if (advance) begin
            v2_d   = v1_q;
            prod_d = prod_t'(mult_res[PW-1:0]);
            id2_d  = id1_q;
            if (accept) begin
                v1_d  = 1'b1;
                a1_d  = op_t'(req_a[int'(grant_idx)*OPW +: OPW]);
                b1_d  = op_t'(req_b[int'(grant_idx)*OPW +: OPW]);
                id1_d = grant_idx;
                // Explicit wrap so non-power-of-two NUM_REQ stays in range.
                ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0
                                                           : grant_idx + ID_W'(1);
            end else begin
                v1_d = 1'b0;
            end
        end

        if (v2_q && resp_ready) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q  <= '0;
            v1_q   <= 1'b0;
            a1_q   <= '0;
            b1_q   <= '0;
            id1_q  <= '0;
            v2_q   <= 1'b0;
            prod_q <= '0;
            id2_q  <= '0;
            cnt_q  <= '0;
        end else begin
            ptr_q  <= ptr_d;
            v1_q   <= v1_d;
            a1_q   <= a1_d;
            b1_q   <= b1_d;
            id1_q  <= id1_d;
            v2_q   <= v2_d;
            prod_q <= prod_d;
            id2_q  <= id2_d;
            cnt_q  <= cnt_d;
        end
    end

    assign resp_valid   = v2_q;
    assign resp_id      = id2_q;
    assign resp_product = prod_q;
    assign ops_count    = cnt_q;

endmodule

// File: tb/tb_mult_share_sched.sv
// -----------------------------------------------------------------------------
// tb_mult_share_sched
// Directed steps followed by a randomized phase. A behavioural model tracks
// which pipeline stages are occupied, the round-robin pointer and the
// response count; expected products are computed with integer multiplies
// and queued in order of acceptance.
// -----------------------------------------------------------------------------
module tb_mult_share_sched;

    localparam int N     = 4;
    localparam int CNT_W = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]     req_valid;
    logic [4*N-1:0]   req_a;
    logic [4*N-1:0]   req_b;
    logic [N-1:0]     req_ready;
    logic             resp_valid;
    logic             resp_ready;
    logic [1:0]       resp_id;
    logic [7:0]       resp_product;
    logic [CNT_W-1:0] ops_count;

    mult_share_sched #(
        .NUM_REQ (N),
        .CNT_W   (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_id      (resp_id),
        .resp_product (resp_product),
        .ops_count    (ops_count)
    );

    // ---------------- model / scoreboard ----------------
    int checks = 0;
    int errors = 0;

    bit               m_v1 = 1'b0;
    bit               m_v2 = 1'b0;
    int               m_ptr = 0;
    logic [CNT_W-1:0] m_cnt = '0;
    logic [9:0]       exp_q[$];   // {id, product} in acceptance order
    int               acc_log[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_model(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [7:0] ref_prod(input int g);
        logic signed [3:0] ta;
        logic signed [3:0] tb;
        int                p;
        ta = req_a[4*g +: 4];
        tb = req_b[4*g +: 4];
        p  = int'(ta) * int'(tb);
        return p[7:0];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b);
        req_valid[i]     = 1'b1;
        req_a[4*i +: 4]  = a;
        req_b[4*i +: 4]  = b;
    endtask

    // Called just after a falling edge with inputs already driven. Checks
    // outputs against the model, then advances the model across the edge.
    task automatic cycle();
        logic [N-1:0] er;
        logic [9:0]   head;
        int           g;
        bit           adv;
        #1;
        adv = !m_v2 || resp_ready;
        g   = (!rst && adv) ? rr_model(req_valid, m_ptr) : -1;
        er  = '0;
        if (g >= 0) er[g] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(er));
        check("resp_valid", 32'(resp_valid), 32'(m_v2));
        if (m_v2) begin
            if (exp_q.size() > 0) head = exp_q[0];
            else                  head = 'x;
            check("resp_id", 32'(resp_id), 32'(head[9:8]));
            check("resp_product", 32'(resp_product), 32'(head[7:0]));
        end
        check("ops_count", 32'(ops_count), 32'(m_cnt));
        @(posedge clk);
        if (rst) begin
            m_v1  = 1'b0;
            m_v2  = 1'b0;
            m_ptr = 0;
            m_cnt = '0;
            exp_q.delete();
        end else begin
            if (m_v2 && resp_ready) begin
                m_cnt++;
                void'(exp_q.pop_front());
            end
            if (adv) begin
                m_v2 = m_v1;
                if (g >= 0) begin
                    m_v1 = 1'b1;
                    exp_q.push_back({2'(g), ref_prod(g)});
                    acc_log.push_back(g);
                    m_ptr = (g + 1) % N;
                end else begin
                    m_v1 = 1'b0;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic expect_resp(input string tag, input logic [1:0] id, input logic [7:0] p);
        #1;
        check({tag, "_valid"}, 32'(resp_valid), 32'd1);
        check({tag, "_id"}, 32'(resp_id), 32'(id));
        check({tag, "_product"}, 32'(resp_product), 32'(p));
    endtask

    // ---------------- directed and random steps ----------------
    int               order_exp[6] = '{0, 1, 2, 3, 0, 1};
    logic [1:0]       held_id;
    logic [7:0]       held_p;
    logic [CNT_W-1:0] held_cnt;

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b1;

        // Reset: requests present must not be accepted.
        @(negedge clk);
        cycle();
        req_valid = 4'b1111;
        cycle();
        rst       = 1'b0;
        req_valid = '0;
        #1;
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_product", 32'(resp_product), 32'd0);
        check("rst_id", 32'(resp_id), 32'd0);
        check("rst_ops_count", 32'(ops_count), 32'd0);

        // Test 1: single requester 0, -3 * 5.
        set_req(0, 4'hD, 4'h5);
        #1;
        check("t1_req_ready", 32'(req_ready), 32'b0001);
        cycle();
        req_valid = '0;
        cycle();
        expect_resp("t1", 2'd0, 8'hF1);
        cycle();
        #1;
        check("t1_ops_count", 32'(ops_count), 32'd1);

        // Test 2: corner products back to back from requesters 1..3.
        set_req(1, 4'h8, 4'h8);
        cycle();
        req_valid = '0;
        set_req(2, 4'h7, 4'h8);
        cycle();
        req_valid = '0;
        set_req(3, 4'h0, 4'hF);
        expect_resp("t2_a", 2'd1, 8'h40);
        cycle();
        req_valid = '0;
        expect_resp("t2_b", 2'd2, 8'hC8);
        cycle();
        expect_resp("t2_c", 2'd3, 8'h00);
        cycle();

        // Test 3: all requesters valid continuously.
        acc_log.delete();
        set_req(0, 4'h1, 4'h2);
        set_req(1, 4'h3, 4'hE);
        set_req(2, 4'hB, 4'h3);
        set_req(3, 4'h6, 4'h9);
        repeat (6) cycle();
        check("t3_accepts", 32'(acc_log.size()), 32'd6);
        for (int k = 0; k < 6 && k < acc_log.size(); k++) begin
            check("t3_order", 32'(acc_log[k]), 32'(order_exp[k]));
        end

        // Test 4: full pipeline, 3 stall cycles, then drain.
        resp_ready = 1'b0;
        #1;
        held_id  = resp_id;
        held_p   = resp_product;
        held_cnt = ops_count;
        check("t4_full", 32'(resp_valid), 32'd1);
        repeat (3) begin
            cycle();
            #1;
            check("t4_hold_valid", 32'(resp_valid), 32'd1);
            check("t4_hold_id", 32'(resp_id), 32'(held_id));
            check("t4_hold_product", 32'(resp_product), 32'(held_p));
            check("t4_hold_count", 32'(ops_count), 32'(held_cnt));
            check("t4_no_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        req_valid  = '0;
        cycle();
        #1;
        check("t4_second_out", 32'(resp_valid), 32'd1);
        cycle();
        #1;
        check("t4_drained", 32'(resp_valid), 32'd0);

        // Test 5: reset with both stages occupied.
        set_req(0, 4'h2, 4'h3);
        cycle();
        set_req(0, 4'h4, 4'h5);
        cycle();
        rst       = 1'b1;
        req_valid = '0;
        set_req(2, 4'h5, 4'h5);
        set_req(3, 4'hF, 4'hF);
        cycle();
        rst = 1'b0;
        #1;
        check("t5_resp_valid", 32'(resp_valid), 32'd0);
        check("t5_ops_count", 32'(ops_count), 32'd0);
        check("t5_grant2", 32'(req_ready), 32'b0100);
        cycle();
        req_valid = '0;
        repeat (3) cycle();

        // Random phase.
        repeat (400) begin
            req_valid  = 4'($urandom_range(0, 15));
            req_a      = 16'($urandom);
            req_b      = 16'($urandom);
            resp_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        req_valid  = '0;
        resp_ready = 1'b1;
        repeat (3) cycle();

        // Test 6: counter wrap from 16'hFFFE through three responses.
        force dut.cnt_q = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut.cnt_q;
        m_cnt = 16'hFFFE;
        @(negedge clk);
        check("t6_preset", 32'(ops_count), 32'hFFFE);
        set_req(0, 4'h1, 4'h1);
        repeat (3) cycle();
        req_valid = '0;
        repeat (3) cycle();
        #1;
        check("t6_wrap", 32'(ops_count), 32'h0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
